// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants, types and helpers for the clock divider bank.
package clk_div_pkg;

  // Default counter / divisor width.
  localparam int DEF_CNT_W = 16;

  // Default half-period (in clk cycles) loaded into every channel at reset.
  localparam int DEF_DIV = 500;

  // Divisor type at the default width.
  typedef logic [DEF_CNT_W-1:0] div_t;

  // Width of a channel index: max(1, clog2(n)).
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_bank_chan.sv
// clk_div_chan: one divider channel. Holds the half-period counter, the active
// and pending divisors, the divided clock and its rise/fall strobes.
// Optional feature macro: CLK_DIV_MID_TICK_EN (mid-half-period strobe).
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wr_div,
  output logic             o_pend_v,
  output logic             o_clk,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_mid
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_pend;
  logic             r_pend_v;
  logic             r_clk;
  logic             r_rise;
  logic             r_fall;
  logic             w_boundary;

  // Last cycle of the current half-period; the divisor is never 0 so div-1 is safe.
  assign w_boundary = (r_cnt == (r_div - CNT_W'(1)));

  // Counter, divided clock, strobes and the pending-divisor handoff.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_div    <= CNT_W'(DEFAULT_DIV);
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_clk    <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      // The bank only issues a write while nothing is pending anywhere.
      if (i_wr) begin
        r_pend   <= i_wr_div;
        r_pend_v <= 1'b1;
      end
      if (!i_en) begin
        // Parked: clock held low, a falling strobe only if we were high.
        r_cnt  <= '0;
        r_clk  <= 1'b0;
        r_rise <= 1'b0;
        r_fall <= r_clk;
        if (r_pend_v) begin
          r_div    <= r_pend;
          r_pend_v <= 1'b0;
        end
      end else if (w_boundary) begin
        r_cnt  <= '0;
        r_clk  <= ~r_clk;
        r_rise <= ~r_clk;
        r_fall <= r_clk;
        // Swap divisors only on a high->low boundary so both halves match.
        if (r_clk && r_pend_v) begin
          r_div    <= r_pend;
          r_pend_v <= 1'b0;
        end
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end
    end
  end

`ifdef CLK_DIV_MID_TICK_EN
  logic             r_mid;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_mid_hit;

  // The counter is about to reach floor(div/2) inside a half-period.
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_mid_hit = i_en && !w_boundary && (r_div >= CNT_W'(2)) &&
                     (w_cnt_inc == (r_div >> 1));

  // Mid strobe registered in the same stage as the clock and edge strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mid <= 1'b0;
    end else begin
      r_mid <= w_mid_hit;
    end
  end

  assign o_mid = r_mid;
`else
  assign o_mid = 1'b0;
`endif

  assign o_pend_v = r_pend_v;
  assign o_clk    = r_clk;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of independent 50% duty clock dividers with a shared
// valid/ready divisor write port. Owns write decode and the ready reduction.
// Optional feature macro: CLK_DIV_MID_TICK_EN (per-channel mid strobe).
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter  int NUM_CH      = 2,
  parameter  int CNT_W       = DEF_CNT_W,
  parameter  int DEFAULT_DIV = DEF_DIV,
  localparam int CH_W        = ch_w(NUM_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_en,
  input  logic [CNT_W-1:0]  i_div,
  input  logic [CH_W-1:0]   i_div_ch,
  input  logic              i_div_valid,
  output logic              o_div_ready,
  output logic [NUM_CH-1:0] o_clk,
  output logic [NUM_CH-1:0] o_rise,
  output logic [NUM_CH-1:0] o_fall,
  output logic [NUM_CH-1:0] o_mid
);

  logic              w_accept;
  logic [CNT_W-1:0]  w_div_clamped;
  logic [NUM_CH-1:0] w_wr;
  logic [NUM_CH-1:0] w_pend_v;

  // A zero divisor would never reach a boundary; treat it as 1.
  assign w_div_clamped = (i_div == '0) ? CNT_W'(1) : i_div;

  // Writes to a channel index beyond NUM_CH match no channel and vanish.
  assign w_accept = i_div_valid && o_div_ready;

  // Only one divisor change may be in flight across the whole bank.
  assign o_div_ready = ~|w_pend_v;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_wr[gi] = w_accept && (i_div_ch == CH_W'(gi));

      clk_div_chan #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (i_en[gi]),
        .i_wr     (w_wr[gi]),
        .i_wr_div (w_div_clamped),
        .o_pend_v (w_pend_v[gi]),
        .o_clk    (o_clk[gi]),
        .o_rise   (o_rise[gi]),
        .o_fall   (o_fall[gi]),
        .o_mid    (o_mid[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed bench for clk_div_bank (3 channels, div 500).
// Expected rise/fall events are queued per channel as stimulus is applied and
// popped by a monitor as the DUT produces strobes.
module tb_clk_div_bank;

  localparam int NCH  = 3;
  localparam int CW   = 16;
  localparam int DDIV = 500;
  localparam int CHW  = clk_div_pkg::ch_w(NCH);

  logic           clk;
  logic           rst;
  logic [NCH-1:0] en;
  logic [CW-1:0]  div;
  logic [CHW-1:0] div_ch;
  logic           div_valid;
  logic           div_ready;
  logic [NCH-1:0] oclk;
  logic [NCH-1:0] o_rise;
  logic [NCH-1:0] o_fall;
  logic [NCH-1:0] o_mid;

  clk_div_bank #(
    .NUM_CH      (NCH),
    .CNT_W       (CW),
    .DEFAULT_DIV (DDIV)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_div       (div),
    .i_div_ch    (div_ch),
    .i_div_valid (div_valid),
    .o_div_ready (div_ready),
    .o_clk       (oclk),
    .o_rise      (o_rise),
    .o_fall      (o_fall),
    .o_mid       (o_mid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endfunction

  // Expected-event scoreboard and a half-period event model per channel.
  typedef struct {
    int t;
    bit rise;
  } ev_t;

  ev_t exp_q[NCH][$];
  int  nxt[NCH];
  bit  nrise[NCH];
  int  hp[NCH];
  bit  run[NCH];
  bit  pend[NCH];
  int  pend_hp[NCH];
  int  pend_after[NCH];
  int  apply_t[NCH];

  function automatic void push_ev(input int ch, input int t, input bit rise);
    ev_t e;
    e.t = t;
    e.rise = rise;
    exp_q[ch].push_back(e);
  endfunction

  function automatic void start_all(input int t_rel);
    for (int ch = 0; ch < NCH; ch++) begin
      run[ch]   = 1'b1;
      pend[ch]  = 1'b0;
      hp[ch]    = DDIV;
      nxt[ch]   = t_rel + DDIV;
      nrise[ch] = 1'b1;
    end
  endfunction

  // Queue every expected edge up to cycle 'upto'; pending divisors take over
  // at the first falling edge strictly after their accept cycle.
  function automatic void gen(input int upto);
    for (int ch = 0; ch < NCH; ch++) begin
      while (run[ch] && nxt[ch] <= upto) begin
        push_ev(ch, nxt[ch], nrise[ch]);
        if (!nrise[ch] && pend[ch] && nxt[ch] > pend_after[ch]) begin
          hp[ch]      = pend_hp[ch];
          pend[ch]    = 1'b0;
          apply_t[ch] = nxt[ch];
        end
        nxt[ch]  += hp[ch];
        nrise[ch] = !nrise[ch];
      end
    end
  endfunction

  // Monitor: every strobe must match the head of its channel's queue.
  ev_t mon_e;
  bit  mid_seen = 1'b0;
  always @(negedge clk) begin
    if ((|o_mid) === 1'b1) mid_seen = 1'b1;
    for (int ch = 0; ch < NCH; ch++) begin
      if (o_rise[ch] === 1'b1 || o_fall[ch] === 1'b1) begin
        if (exp_q[ch].size() > 0) begin
          mon_e = exp_q[ch].pop_front();
          chk($sformatf("edge_time_ch%0d", ch), cyc, mon_e.t);
          chk($sformatf("edge_kind_ch%0d", ch), {29'd0, o_rise[ch], o_fall[ch], oclk[ch]},
              mon_e.rise ? 32'd5 : 32'd2);
        end else begin
          chk($sformatf("edge_unexpected_ch%0d_qsize", ch), exp_q[ch].size(), 1);
        end
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_write(input int ch, input int val);
    div_valid = 1'b1;
    div       = CW'(val);
    div_ch    = CHW'(ch);
    @(posedge clk);
    #1;
    div_valid = 1'b0;
  endtask

  // Write a divisor to a real channel and follow it through to its apply edge.
  task automatic write_tracked(input int ch, input int val);
    int a;
    int h;
    int nv;
    nv = (val == 0) ? 1 : val;
    gen(cyc + 1);
    a = cyc + 1;
    pend[ch]       = 1'b1;
    pend_hp[ch]    = nv;
    pend_after[ch] = a;
    if (!run[ch]) begin
      hp[ch]      = nv;
      pend[ch]    = 1'b0;
      apply_t[ch] = a + 1;
      h = a + 2;
    end else begin
      h = a + 2 * hp[ch] + 2;
    end
    drive_write(ch, val);
    chk($sformatf("ready_low_after_accept_ch%0d", ch), div_ready, 0);
    gen(h);
    chk($sformatf("apply_found_ch%0d", ch), pend[ch], 0);
    if (apply_t[ch] - 1 > a) begin
      wait_cyc(apply_t[ch] - 1);
      chk($sformatf("ready_low_before_apply_ch%0d", ch), div_ready, 0);
    end
    wait_cyc(apply_t[ch]);
    chk($sformatf("ready_high_after_apply_ch%0d", ch), div_ready, 1);
    wait_cyc(h);
  endtask

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int t1;
    int tgt;
    int mid_exp;

    rst       = 1'b1;
    en        = '1;
    div       = '0;
    div_ch    = '0;
    div_valid = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clk", oclk, 0);
    chk("rst_rise", o_rise, 0);
    chk("rst_fall", o_fall, 0);
    chk("rst_mid", o_mid, 0);
    chk("rst_ready", div_ready, 1);

    // Release with all channels enabled at the default divisor.
    rst = 1'b0;
    t0  = cyc;
    start_all(t0);
    gen(t0 + 1600);
    wait_cyc(t0 + 1600);
    chk("ch1_high_before_write", oclk[1], 1);

    // Mid-high write of 3 to ch1, then a zero write that must act as 1.
    write_tracked(1, 3);
    write_tracked(1, 0);

    // Disable ch0 while high, then program it while parked.
    chk("ch0_high_before_disable", oclk[0], 1);
    en[0]  = 1'b0;
    run[0] = 1'b0;
    push_ev(0, cyc + 1, 1'b0);
    wait_cyc(cyc + 1);
    chk("disable_clk0", oclk[0], 0);
    chk("disable_fall0", o_fall[0], 1);
    write_tracked(0, 4);

    // Re-enable ch0: first rise one half-period later.
    en[0]    = 1'b1;
    run[0]   = 1'b1;
    nxt[0]   = cyc + hp[0];
    nrise[0] = 1'b1;
    tgt = cyc + 40;
    gen(tgt);
    wait_cyc(tgt);

    // Write to a nonexistent channel: accepted and dropped.
    gen(cyc + 1);
    drive_write(3, 7);
    chk("ready_after_dropped_write", div_ready, 1);
    tgt = cyc + 20;
    gen(tgt);
    wait_cyc(tgt);

    // div=8 on ch2 and mid strobe window.
    write_tracked(2, 8);
    tgt = cyc + 40;
    gen(tgt);
    for (int k = 0; k < 32; k++) begin
      @(posedge clk);
      #1;
`ifdef CLK_DIV_MID_TICK_EN
      mid_exp = (((cyc - apply_t[2]) % 8) == 4) ? 1 : 0;
`else
      mid_exp = 0;
`endif
      chk("mid_ch2", o_mid[2], mid_exp);
      chk("mid_ch1_div1", o_mid[1], 0);
    end
    wait_cyc(tgt);

    // Reset while a write is pending: the write is lost.
    gen(cyc + 1);
    drive_write(0, 5);
    chk("ready_low_before_reset", div_ready, 0);
    rst = 1'b1;
    for (int ch = 0; ch < NCH; ch++) begin
      run[ch]  = 1'b0;
      pend[ch] = 1'b0;
    end
    tgt = cyc + 2;
    wait_cyc(cyc + 1);
    chk("midrun_rst_clk", oclk, 0);
    chk("midrun_rst_ready", div_ready, 1);
    wait_cyc(tgt);
    rst = 1'b0;
    t1  = cyc;
    start_all(t1);
    gen(t1 + 510);
    wait_cyc(t1 + 510);
    @(negedge clk);
    #1;

    for (int ch = 0; ch < NCH; ch++) begin
      chk($sformatf("missing_edges_ch%0d", ch), exp_q[ch].size(), 0);
    end
`ifndef CLK_DIV_MID_TICK_EN
    chk("mid_never_seen", mid_seen, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
